// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-aware 2:1 AXI-Stream mux select arbiter with stall watchdog
//   Ports:
//     aclk, areset        clock, synchronous active-high reset
//     in_tvalid[1:0]      tvalid of the two mux inputs
//     out_tvalid/tready   handshake at the mux output (ahead of the register slice)
//     out_tlast           tlast at the mux output
//     select              registered mux select (0 = input 0, 1 = input 1)
//     busy                packet open (state PKT), registered
//     timeout_err         sticky watchdog flag (TIMEOUT > 0 only)
//     pkt_cnt0/pkt_cnt1   per-input completed-packet counters, only with AXIS_PKT_ARBITER_PKT_CNT_EN
//   Parameters: PRIORITY_MODE (0 round-robin, 1 fixed priority), TIMEOUT (0 disables), CNT_W
module axis_pkt_arbiter #(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 0,
    parameter int CNT_W         = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic [1:0]       in_tvalid,
    input  logic             out_tvalid,
    input  logic             out_tready,
    input  logic             out_tlast,
    output logic             select,
    output logic             busy,
    output logic             timeout_err
`ifdef AXIS_PKT_ARBITER_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
`endif
);
    typedef enum logic {IDLE, PKT} state_t;
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);
    state_t           state_q, state_d;
    logic             select_q, select_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             err_q, err_d;
    logic             beat, last, rr_grant, fp_grant, grant;
    assign beat     = out_tvalid && out_tready;
    assign last     = beat && out_tlast;
    assign rr_grant = in_tvalid[~select_q] ? ~select_q : select_q;
    assign fp_grant = in_tvalid[0] ? 1'b0 : in_tvalid[1] ? 1'b1 : select_q;
    assign grant    = (PRIORITY_MODE != 0) ? fp_grant : rr_grant;
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        if (last) begin
            state_d  = IDLE;
            select_d = grant;
        end else if (state_q == IDLE && beat) begin
            state_d  = PKT;
        end else if (state_q == IDLE && !in_tvalid[select_q] && in_tvalid[~select_q]) begin
            // idle and the current input has nothing to offer: hand over early
            select_d = ~select_q;
        end
        // with TIMEOUT = 0, TMAX = 0 pins the counter at zero
        wd_d  = (state_q == PKT && !beat) ? ((wd_q == TMAX) ? wd_q : wd_q + 1'b1) : '0;
        err_d = err_q || (TIMEOUT != 0 && wd_d == TMAX);
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= IDLE;
            select_q <= 1'b0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end
    assign select      = select_q;
    assign busy        = (state_q == PKT);
    assign timeout_err = err_q;
`ifdef AXIS_PKT_ARBITER_PKT_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (last) begin
            if (select_q) cnt1_q <= cnt1_q + 1'b1;
            else          cnt0_q <= cnt0_q + 1'b1;
        end
    end
    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// tb_axis_pkt_arbiter: directed vector bench for axis_pkt_arbiter (round-robin and fixed-priority instances)
module tb_axis_pkt_arbiter;
    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [1:0] rr_iv = 2'b00, fp_iv = 2'b00;
    logic       rr_v = 1'b0, rr_r = 1'b0, rr_l = 1'b0;
    logic       fp_v = 1'b0, fp_r = 1'b0, fp_l = 1'b0;
    logic       rr_sel, rr_busy, rr_err, fp_sel, fp_busy, fp_err;
`ifdef AXIS_PKT_ARBITER_PKT_CNT_EN
    logic [15:0] rr_c0, rr_c1, fp_c0, fp_c1;
`endif
    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axis_pkt_arbiter #(.PRIORITY_MODE(0), .TIMEOUT(4), .CNT_W(16)) u_rr (
        .aclk(aclk), .areset(areset), .in_tvalid(rr_iv),
        .out_tvalid(rr_v), .out_tready(rr_r), .out_tlast(rr_l),
        .select(rr_sel), .busy(rr_busy), .timeout_err(rr_err)
`ifdef AXIS_PKT_ARBITER_PKT_CNT_EN
        , .pkt_cnt0(rr_c0), .pkt_cnt1(rr_c1)
`endif
    );

    axis_pkt_arbiter #(.PRIORITY_MODE(1), .TIMEOUT(0), .CNT_W(16)) u_fp (
        .aclk(aclk), .areset(areset), .in_tvalid(fp_iv),
        .out_tvalid(fp_v), .out_tready(fp_r), .out_tlast(fp_l),
        .select(fp_sel), .busy(fp_busy), .timeout_err(fp_err)
`ifdef AXIS_PKT_ARBITER_PKT_CNT_EN
        , .pkt_cnt0(fp_c0), .pkt_cnt1(fp_c1)
`endif
    );

    typedef struct {
        logic [1:0] iv;
        logic       v, r, l;
        logic       sel, busy, err;
    } vec_t;
    vec_t tbl[25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic rr_drive(input logic [1:0] iv, input logic v, input logic r, input logic l);
        rr_iv = iv; rr_v = v; rr_r = r; rr_l = l;
    endtask

    task automatic fp_drive(input logic [1:0] iv, input logic v, input logic r, input logic l);
        fp_iv = iv; fp_v = v; fp_r = r; fp_l = l;
    endtask

    initial begin
        // round-robin, TIMEOUT=4: {in_tvalid, out_tvalid, out_tready, out_tlast} -> {select, busy, timeout_err}
        tbl[0]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[17] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[20] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[21] = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[22] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[23] = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[24] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        cyc(); cyc();
        chk("rst_rr_sel", rr_sel, 0);
        chk("rst_rr_busy", rr_busy, 0);
        chk("rst_rr_err", rr_err, 0);
        chk("rst_fp_sel", fp_sel, 0);
        chk("rst_fp_busy", fp_busy, 0);
        areset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            rr_drive(tbl[i].iv, tbl[i].v, tbl[i].r, tbl[i].l);
            cyc();
            chk($sformatf("vec%0d_sel", i), rr_sel, tbl[i].sel);
            chk($sformatf("vec%0d_busy", i), rr_busy, tbl[i].busy);
            chk($sformatf("vec%0d_err", i), rr_err, tbl[i].err);
        end
        rr_drive(2'b00, 1'b0, 1'b0, 1'b0);

        // fixed priority: input 1 holds the grant through its packet even once input 0 asks
        fp_drive(2'b10, 1'b0, 1'b0, 1'b0); cyc();
        chk("fp_idle_toggle", fp_sel, 1);
        fp_drive(2'b11, 1'b0, 1'b0, 1'b0); cyc();
        chk("fp_no_withdraw", fp_sel, 1);
        fp_drive(2'b11, 1'b1, 1'b1, 1'b0); cyc();
        chk("fp_pkt_busy", fp_busy, 1);
        fp_drive(2'b11, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc();
        chk("fp_locked_sel", fp_sel, 1);
        chk("fp_no_watchdog", fp_err, 0);
        fp_drive(2'b11, 1'b1, 1'b1, 1'b1); cyc();
        chk("fp_last_to_0", fp_sel, 0);
        chk("fp_last_idle", fp_busy, 0);
        cyc();
        chk("fp_keep_0", fp_sel, 0);
        fp_drive(2'b10, 1'b1, 1'b1, 1'b1); cyc();
        chk("fp_grant_1", fp_sel, 1);
        fp_drive(2'b00, 1'b0, 1'b0, 1'b0);

        // reset abandons an open packet on input 1 after 2 of 5 beats
        rr_drive(2'b10, 1'b1, 1'b1, 1'b0); cyc(); cyc();
        chk("pre_rst_busy", rr_busy, 1);
        chk("pre_rst_sel", rr_sel, 1);
        rr_drive(2'b00, 1'b0, 1'b0, 1'b0);
        areset = 1'b1; cyc(); areset = 1'b0;
        chk("mid_rst_sel", rr_sel, 0);
        chk("mid_rst_busy", rr_busy, 0);
        chk("mid_rst_err", rr_err, 0);

        rr_drive(2'b10, 1'b0, 1'b0, 1'b0); cyc();
        chk("post_rst_sel1", rr_sel, 1);
        rr_drive(2'b10, 1'b1, 1'b1, 1'b1); cyc();
        chk("one_beat_sel", rr_sel, 1);
        chk("one_beat_busy", rr_busy, 0);
        rr_drive(2'b10, 1'b1, 1'b1, 1'b0); cyc();
        chk("restart_busy", rr_busy, 1);
        rr_drive(2'b10, 1'b1, 1'b1, 1'b1); cyc();
        chk("restart_done", rr_busy, 0);
        rr_drive(2'b00, 1'b0, 1'b0, 1'b0);

`ifdef AXIS_PKT_ARBITER_PKT_CNT_EN
        areset = 1'b1; cyc(); areset = 1'b0;
        chk("cnt_rst0", rr_c0, 0);
        rr_drive(2'b01, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 65537; i++) cyc();
        rr_drive(2'b00, 1'b0, 1'b0, 1'b0);
        chk("cnt0_wrap", rr_c0, 1);
        chk("cnt1_zero", rr_c1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 SHALL have parameter PRIORITY_MODE, default 0; 0 = round-robin, 1 = fixed priority (input 0 wins).
REQ-002 SHALL have parameter TIMEOUT, default 0; stall-cycle limit inside a packet; 0 disables the watchdog.
REQ-003 SHALL have parameter CNT_W, default 16; width of the watchdog and packet counters.
REQ-004 SHALL have port aclk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port areset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_tvalid  input  2  tvalid of mux inputs [1:0].
REQ-007 SHALL have port out_tvalid  input  1  tvalid at the mux output, ahead of the register slice.
REQ-008 SHALL have port out_tready  input  1  tready at the mux output.
REQ-009 SHALL have port out_tlast  input  1  tlast at the mux output.
REQ-010 SHALL have port select  output  1  registered mux select; 0 = input 0, 1 = input 1.
REQ-011 SHALL have port busy  output  1  high while a packet is in progress (state PKT).
REQ-012 SHALL have port timeout_err  output  1  sticky watchdog flag.

Function
REQ-013 SHALL define a beat as out_tvalid && out_tready in one cycle, and a last beat as a beat with out_tlast=1.
REQ-014 SHALL implement FSM states IDLE (no packet open) and PKT (packet open, select locked).
REQ-015 SHALL, in IDLE on a non-last beat, go to PKT next cycle with select unchanged.
REQ-016 SHALL, in IDLE or PKT on a last beat, go to IDLE and apply the next-grant rule at that same clock edge.
REQ-017 SHALL, in PKT with no last beat, hold select and state.
REQ-018 SHALL, in IDLE with no beat, in_tvalid[select]=0 and in_tvalid[~select]=1, toggle select at the next edge.
REQ-019 SHALL never change select while in_tvalid[select]=1 and no last beat occurs, so an offered beat is never withdrawn.
REQ-020 SHALL, round-robin next-grant: select <= ~select if in_tvalid[~select]=1, else hold.
REQ-021 SHALL, fixed-priority next-grant: select <= 0 if in_tvalid[0], else 1 if in_tvalid[1], else hold.
REQ-022 SHALL, on a single-beat packet (last beat in IDLE), remain in IDLE and apply the next-grant rule.
REQ-023 SHALL drive busy = (state == PKT), registered, with zero combinational path from inputs.
REQ-024 SHALL, when TIMEOUT>0, count consecutive PKT cycles without a beat, clear the count on any beat or on leaving PKT, and set timeout_err when the count reaches TIMEOUT.
REQ-025 SHALL take no corrective action on timeout; select stays locked and timeout_err holds until reset.
REQ-026 SHALL saturate the watchdog counter at TIMEOUT and never wrap it.

Reset
REQ-027 SHALL, while areset=1 at a clock edge, set state=IDLE, select=0, busy=0, timeout_err=0, and all counters to 0.
REQ-028 SHALL abandon a packet open mid-operation on reset; the next beat after reset is treated as a packet start.

Configuration
REQ-029 SHALL, with macro AXIS_PKT_ARBITER_PKT_CNT_EN defined, add outputs pkt_cnt0 and pkt_cnt1, each CNT_W bits wide.
REQ-030 SHALL increment pkt_cnt0 or pkt_cnt1 on each last beat according to select, wrap modulo 2^CNT_W, and reset both to 0.
REQ-031 SHALL, without AXIS_PKT_ARBITER_PKT_CNT_EN, omit these ports and counters; all other behaviour is identical.

Verification
REQ-032 SHALL cover: PRIORITY_MODE=0, both inputs always valid, 3-beat packets -> select alternates 0,1,0,1, changing only at the edge after each last beat.
REQ-033 SHALL cover: in_tvalid=2'b10 after reset -> select=1 one cycle later; a 1-beat packet then gives select=1 held, busy never set.
REQ-034 SHALL cover: PRIORITY_MODE=1, input 1 mid-packet when input 0 asserts -> select holds 1 until input 1's last beat, then becomes 0.
REQ-035 SHALL cover: TIMEOUT=4, PKT with out_tready=0 for 4 cycles -> timeout_err=1 after the 4th stall cycle, sticky through later beats until areset.
REQ-036 SHALL cover: areset asserted in PKT after 2 of 5 beats -> next cycle state=IDLE, select=0, busy=0; with AXIS_PKT_ARBITER_PKT_CNT_EN, 65537 input-0 packets with CNT_W=16 -> pkt_cnt0=1.
